// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multicycle core with one external
// single-port memory behind a req/ready handshake and a debug read port.
module cpu_core_param #(
    parameter int          DATA_W   = 16,
    parameter int          ADDR_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    localparam logic [3:0] F_ADD = 4'h5;
    localparam logic [3:0] F_SUB = 4'h9;
    localparam logic [3:0] F_AND = 4'h1;
    localparam logic [3:0] F_OR  = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;
    localparam logic [3:0] F_MOV = 4'hD;
    localparam logic [3:0] F_CMP = 4'hB;

    state_t            state_q, state_d;
    logic              run_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              z_q, z_d;
    logic              l_q, l_d;
    logic              n_q, n_d;
    logic [DATA_W-1:0] rf_q [16];
    logic [DATA_W-1:0] rf_d [16];

    logic [3:0]        op, rd, ext, rs, fn;
    logic [7:0]        imm;
    logic [DATA_W-1:0] rd_val, rs_val, opb, alu_y;
    logic [ADDR_W-1:0] rs_addr, br_tgt;
    logic              is_reg, is_imm, is_alu, is_cmp;
    logic              is_ld, is_st, is_jmp, is_br, is_halt;
    logic              take;

    assign op     = ir_q[15:12];
    assign rd     = ir_q[11:8];
    assign ext    = ir_q[7:4];
    assign rs     = ir_q[3:0];
    assign imm    = ir_q[7:0];
    assign rd_val = rf_q[rd];
    assign rs_val = rf_q[rs];

    // register values become addresses by truncation or zero-extension
    assign rs_addr = ADDR_W'(rs_val);
    assign br_tgt  = pc_q - ADDR_W'(1) + ADDR_W'($signed(imm));

    always_comb begin
        is_halt = (ir_q == 16'hFFFF);
        is_reg  = (op == 4'h0);
        is_imm  = op inside {F_ADD, F_SUB, F_AND, F_OR,
                             F_XOR, F_MOV, F_CMP};
        fn      = is_reg ? ext : op;
        is_alu  = (is_reg || is_imm) &&
                  (fn inside {F_ADD, F_SUB, F_AND, F_OR,
                              F_XOR, F_MOV});
        is_cmp  = (is_reg || is_imm) && (fn == F_CMP);
        is_ld   = (op == 4'h4) && (ext == 4'h0);
        is_st   = (op == 4'h4) && (ext == 4'h4);
        is_jmp  = (op == 4'h4) && (ext == 4'hC);
        is_br   = (op == 4'hC);
    end

    always_comb begin
        opb = rs_val;
        if (!is_reg) begin
            if (fn inside {F_AND, F_OR, F_XOR}) begin
                opb = DATA_W'(imm);
            end else begin
                opb = DATA_W'($signed(imm));
            end
        end
    end

    always_comb begin
        alu_y = opb;
        case (fn)
            F_ADD:   alu_y = rd_val + opb;
            F_SUB:   alu_y = rd_val - opb;
            F_AND:   alu_y = rd_val & opb;
            F_OR:    alu_y = rd_val | opb;
            F_XOR:   alu_y = rd_val ^ opb;
            default: alu_y = opb;
        endcase
    end

    // the rd field doubles as the condition code for branches and jumps
    always_comb begin
        take = 1'b0;
        case (rd)
            4'h0:    take = z_q;
            4'h1:    take = !z_q;
            4'hA:    take = l_q;
            4'hC:    take = n_q;
            4'hE:    take = 1'b1;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        z_d       = z_q;
        l_d       = l_q;
        n_d       = n_q;
        rf_d      = rf_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                    if (mem_ready) begin
                        ir_d    = mem_rdata[15:0];
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                retire  = 1'b1;
                state_d = S_FETCH;
                unique case (1'b1)
                    is_halt: state_d = S_HALT;
                    is_alu:  rf_d[rd] = alu_y;
                    is_cmp: begin
                        z_d = (rd_val == opb);
                        l_d = (rd_val < opb);
                        n_d = ($signed(rd_val) < $signed(opb));
                    end
                    is_ld, is_st: begin
                        retire  = 1'b0;
                        state_d = S_MEM;
                    end
                    is_jmp: if (take) pc_d = rs_addr;
                    is_br:  if (take) pc_d = br_tgt;
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_st;
                mem_addr  = rs_addr;
                mem_wdata = rd_val;
                if (mem_ready) begin
                    if (is_ld) begin
                        rf_d[rd] = mem_rdata;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            run_q   <= 1'b0;
            pc_q    <= PC_RST;
            ir_q    <= '0;
            z_q     <= 1'b0;
            l_q     <= 1'b0;
            n_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            l_q     <= l_d;
            n_q     <= n_d;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign pc       = pc_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed programs plus random ALU/branch programs
// checked against an instruction-level model; second core at 32/8 widths.
`timescale 1ns/1ps
module tb_cpu_core_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req, we, rdy, ret, hlt;
    logic [15:0] addr, wdata, rdata, pcv, dbgd;
    logic [3:0]  dbga;

    logic        req32, we32, ret32, hlt32;
    logic        rdy32 = 1'b1;
    logic [7:0]  addr32, pc32;
    logic [31:0] wdata32, rdata32, dbgd32;
    logic [3:0]  dbga32;

    cpu_core_param #(.DATA_W(16), .ADDR_W(16), .RESET_PC(0)) dut (
        .clock(clk), .reset(rst_n),
        .mem_req(req), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata), .mem_ready(rdy),
        .pc(pcv), .retire(ret), .halted(hlt),
        .dbg_addr(dbga), .dbg_data(dbgd)
    );

    cpu_core_param #(.DATA_W(32), .ADDR_W(8), .RESET_PC(0)) dut32 (
        .clock(clk), .reset(rst_n),
        .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
        .mem_wdata(wdata32), .mem_rdata(rdata32), .mem_ready(rdy32),
        .pc(pc32), .retire(ret32), .halted(hlt32),
        .dbg_addr(dbga32), .dbg_data(dbgd32)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] mem [0:65535];
    logic [31:0] mem32 [0:255];
    assign rdata32 = mem32[addr32];

    int          lat = 0;
    bit          lat_rand = 0;
    bit          block_wr = 0;
    int          cnt = 0;
    int          cur_lat = 0;
    logic        req_s = 0, rdy_s = 0, we_s = 0;
    logic [15:0] addr_s = 0, wdata_s = 0;
    int          wr_n = 0;
    logic [15:0] wr_addr = 0, wr_data = 0;
    int          cyc = 0;
    int          retq[$];

    logic [15:0] mr [16];
    int          mret;
    logic [15:0] mpc;

    logic [3:0]  codes [7] = '{4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hD, 4'hB};
    logic [3:0]  conds [6] = '{4'h0, 4'h1, 4'hA, 4'hC, 4'hE, 4'h3};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // memory: ready after cur_lat wait cycles, writes land on completion
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0;
            rdy = 1'b0;
            req_s = 1'b0;
            rdy_s = 1'b0;
        end else begin
            if (req_s && rdy_s) begin
                if (we_s) begin
                    mem[addr_s] = wdata_s;
                    wr_n++;
                    wr_addr = addr_s;
                    wr_data = wdata_s;
                end
                cnt = 0;
            end
            if (req) begin
                if (req_s && !rdy_s) begin
                    chk("hold_addr", addr, addr_s);
                    chk("hold_we", we, we_s);
                    chk("hold_wdata", wdata, wdata_s);
                end
                if (cnt == 0) begin
                    cur_lat = lat_rand ? int'($urandom_range(2, 0)) : lat;
                end
                rdy = (cnt >= cur_lat) && !(block_wr && we);
                cnt++;
            end else begin
                cnt = 0;
                rdy = 1'b0;
            end
            req_s = req;
            rdy_s = rdy;
            we_s = we;
            addr_s = addr;
            wdata_s = wdata;
        end
        rdata = mem[addr];
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] p[$], input int lv,
                         input bit lr);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        foreach (p[i]) mem[i] = p[i];
        lat = lv;
        lat_rand = lr;
        block_wr = 0;
        wr_n = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;
        retq.delete();
    endtask

    task automatic run(input int budget);
        for (int i = 0; i < budget && hlt !== 1'b1; i++) begin
            step();
            if (ret) retq.push_back(cyc);
        end
        chk("halted", hlt, 1);
    endtask

    task automatic rreg(input int r, output logic [15:0] v);
        dbga = 4'(r);
        #1 v = dbgd;
    endtask

    task automatic chk_ret(input string tag, input int e[$]);
        chk({tag, "_count"}, retq.size(), e.size());
        foreach (e[i]) begin
            chk(tag, (i < retq.size()) ? retq[i] : -1, e[i]);
        end
    endtask

    // instruction-level reference: one loop iteration per instruction
    task automatic model_run();
        logic [15:0] ins, b, a;
        logic [3:0]  op, rd, ext, f;
        logic [7:0]  imm;
        logic        z, l, n, t;
        for (int i = 0; i < 16; i++) mr[i] = '0;
        z = 0; l = 0; n = 0;
        mpc = 0;
        mret = 0;
        for (int s = 0; s < 500; s++) begin
            ins = mem[mpc];
            a = mpc;
            mpc = mpc + 1;
            mret++;
            if (ins == 16'hFFFF) break;
            op = ins[15:12];
            rd = ins[11:8];
            ext = ins[7:4];
            imm = ins[7:0];
            f = (op == 0) ? ext : op;
            if (op == 4'h0 || op inside {4'h5, 4'h9, 4'h1, 4'h2,
                                         4'h3, 4'hD, 4'hB}) begin
                if (op == 0) b = mr[ins[3:0]];
                else if (f inside {4'h1, 4'h2, 4'h3}) b = {8'h00, imm};
                else b = {{8{imm[7]}}, imm};
                case (f)
                    4'h5: mr[rd] = mr[rd] + b;
                    4'h9: mr[rd] = mr[rd] - b;
                    4'h1: mr[rd] = mr[rd] & b;
                    4'h2: mr[rd] = mr[rd] | b;
                    4'h3: mr[rd] = mr[rd] ^ b;
                    4'hD: mr[rd] = b;
                    4'hB: begin
                        z = (mr[rd] == b);
                        l = (mr[rd] < b);
                        n = ($signed(mr[rd]) < $signed(b));
                    end
                    default: ;
                endcase
            end else if (op == 4'hC) begin
                case (rd)
                    4'h0: t = z;
                    4'h1: t = !z;
                    4'hA: t = l;
                    4'hC: t = n;
                    4'hE: t = 1'b1;
                    default: t = 1'b0;
                endcase
                if (t) mpc = a + {{8{imm[7]}}, imm};
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] p[$];
        bit          found;
        int          k;

        dbga = 0;
        dbga32 = 0;
        rdy = 0;
        rdata = 0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) mem32[i] = '0;
        mem32[0] = 32'h0000_D1FF;
        mem32[1] = 32'h0000_5101;
        mem32[2] = 32'h0000_CEFB;

        #3;
        chk("rst_req", req, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pc", pcv, 0);
        chk("rst_retire", ret, 0);
        chk("rst_halted", hlt, 0);

        start('{16'hD105, 16'h51FD, 16'hFFFF}, 0, 0);
        run(60);
        chk_ret("t1_retire", '{2, 4, 6});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_idle_req", req, 0);
        end
        rreg(1, v);
        chk("t1_r1", v, 16'd2);

        start('{16'hD105, 16'h51FD, 16'hFFFF}, 3, 0);
        run(100);
        chk_ret("t2_retire", '{5, 10, 15});
        rreg(1, v);
        chk("t2_r1", v, 16'd2);

        p = '{16'hD207, 16'hB207, 16'hC003, 16'hD611,
              16'hFFFF, 16'hD622, 16'hFFFF};
        start(p, 0, 0);
        run(60);
        rreg(6, v);
        chk("beq_taken_r6", v, 16'h22);
        chk("beq_taken_pc", pcv, 16'd7);

        p[1] = 16'hB208;
        start(p, 0, 0);
        run(60);
        rreg(6, v);
        chk("beq_fall_r6", v, 16'h11);
        chk("beq_fall_pc", pcv, 16'd5);

        p[0] = 16'hD2FF;
        p[1] = 16'hB201;
        p[2] = 16'hCC03;
        start(p, 0, 0);
        run(60);
        rreg(6, v);
        chk("blt_r6", v, 16'h22);

        start('{16'hD340, 16'hD45A, 16'h4443, 16'h4503, 16'hFFFF}, 0, 0);
        run(60);
        chk_ret("t4_retire", '{2, 4, 7, 10, 12});
        chk("t4_wr_count", wr_n, 1);
        chk("t4_wr_addr", wr_addr, 16'h40);
        chk("t4_wr_data", wr_data, 16'h5A);
        chk("t4_mem40", mem[16'h40], 16'h5A);
        rreg(5, v);
        chk("t4_r5", v, 16'h5A);

        start('{16'hD340, 16'hD45A, 16'h4443, 16'hFFFF}, 0, 0);
        mem[16'h40] = 16'h1234;
        block_wr = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = req && we;
        end
        chk("t5_reached_store", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_req_drop", req, 0);
        chk("t5_we_drop", we, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("t5_pc", pcv, 16'd0);
        for (int i = 0; i < 16; i++) begin
            rreg(i, v);
            chk("t5_reg", v, 16'd0);
        end
        chk("t5_wr_count", wr_n, 0);
        chk("t5_mem40", mem[16'h40], 16'h1234);

        start('{16'hFFFF}, 0, 0);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (ret32 && k == 2) chk("w32_branch_cycle", cyc, 6);
            if (ret32) k++;
        end
        chk("w32_retires", k, 3);
        chk("w32_pc", pc32, 8'd253);
        dbga32 = 4'd1;
        #1;
        chk("w32_r1", dbgd32, 32'd0);

        for (int r = 0; r < 3; r++) begin
            p.delete();
            for (int i = 0; i < 24; i++) begin
                k = $urandom_range(3, 0);
                case (k)
                    0: v = {4'h0, 4'($urandom), codes[$urandom_range(6, 0)],
                            4'($urandom)};
                    1: v = {codes[$urandom_range(6, 0)], 4'($urandom),
                            8'($urandom)};
                    2: v = {4'hD, 4'($urandom), 8'($urandom)};
                    default: v = {4'hC, conds[$urandom_range(5, 0)], 8'h02};
                endcase
                p.push_back(v);
            end
            repeat (3) p.push_back(16'hFFFF);
            start(p, 0, 1);
            model_run();
            run(600);
            chk("rand_retires", retq.size(), mret);
            chk("rand_pc", pcv, mpc);
            for (int i = 0; i < 16; i++) begin
                rreg(i, v);
                chk("rand_reg", v, mr[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_core_param.md
# cpu_core_param

Parametrised multicycle CPU core, successor to the fixed 16-bit datapath. It generalises data and address width and replaces the on-chip instruction/storage RAMs with one external single-port memory behind a req/ready handshake. It adds flags-based conditional branches and jumps, load/store, halt, and a debug register-read port. It sits at the top of the puzzle controller and fetches program and data from the shared memory arbiter.

## Interface
- DATA_W, 16, register and ALU width (≥16)
- ADDR_W, 16, memory address width (≥8)
- RESET_PC, 0, PC value after reset
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  memory request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  store data
- mem_rdata  input  DATA_W  read data; instruction = mem_rdata[15:0]
- mem_ready  input  1  transfer completes in the cycle mem_req && mem_ready
- pc  output  ADDR_W  current PC register
- retire  output  1  one-cycle pulse per completed instruction
- halted  output  1  core stopped
- dbg_addr  input  4  debug register select
- dbg_data  output  DATA_W  combinational read of register dbg_addr

## Operation
- Register file: 16 × DATA_W, all zero on reset. r0 is an ordinary register. Flags Z, L (unsigned less), N (signed less) are zero on reset.
- Encoding: op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm=[7:0].
- op 0000, register form, selected by ext:
  - ADD 0101, SUB 1001, AND 0001, OR 0010, XOR 0011: rd ← rd op rs.
  - MOV 1101: rd ← rs.
  - CMP 1011: sets Z=(rd==rs), L=(rd<rs unsigned), N=(rd<rs signed); no register write.
- Immediate form uses the same op values (0101, 1001, 0001, 0010, 0011, 1101, 1011) with imm in place of rs.
  - imm is sign-extended for ADDI, SUBI, MOVI and CMPI; zero-extended for ANDI, ORI and XORI.
- op 0100, selected by ext:
  - LOAD 0000: rd ← mem[rs].
  - STOR 0100: mem[rs] ← rd.
  - Jcond 1100: PC ← rs, condition taken from rd.
- op 1100, Bcond: PC ← addr_of_branch + sext(imm), condition taken from rd.
- Conditions: 0000 EQ (Z), 0001 NE (!Z), 1010 LO (L), 1100 LT (N), 1110 UC (always); all other codes are never taken.
- 16'hFFFF is HALT. Every other unlisted encoding is a NOP, which retires.
- Width rules:
  - Arithmetic wraps mod 2^DATA_W.
  - PC arithmetic wraps mod 2^ADDR_W.
  - Register-to-address uses the low ADDR_W bits, zero-extended if ADDR_W > DATA_W.
  - Only ALU ops other than CMP write flags? No: only CMP/CMPI write flags.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On ready: IR ← instr, PC ← PC+1, go to EXEC.
  - EXEC: ALU/MOV write rd; CMP writes flags; a taken branch or jump loads PC; retire=1; go to FETCH. LOAD/STOR go to MEM. HALT sets retire=1 and goes to HALT.
  - MEM: mem_req=1, mem_addr=rs, mem_we=(STOR), mem_wdata=rd. On ready: LOAD writes rd ← mem_rdata, retire=1, go to FETCH.
  - HALT: halted=1, mem_req=0. Only reset exits.
- Handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
  - mem_req drops for at least the EXEC cycle between transfers.
  - mem_ready while mem_req=0 is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pc=RESET_PC, retire=0, halted=0; state=FETCH.
- Reset asserted mid-transfer (FETCH or MEM) aborts immediately. No register write or memory write is committed; mem_req drops asynchronously.
- First fetch request is issued in the first clock after reset deasserts.
- Zero-wait latency:
  - ALU, branch, jump, NOP, HALT: 2 cycles.
  - LOAD and STOR: 3 cycles.
  - Each cycle with mem_ready=0 while requesting adds one cycle.
- retire is high in the final cycle of each instruction, so retires are at least 2 cycles apart.
- Branch offset is relative to the branch's own address; disp 0 is a self-loop.
- dbg_data reflects register writes from the cycle after the writing edge.

## Test plan
- Reset, then zero-wait memory with program MOVI r1,5; ADDI r1,-3; HALT → dbg r1=2; retire pulses 3 times at cycles 2, 4 and 6; halted=1; mem_req stays 0 thereafter.
- Same program with mem_ready low for 3 cycles on every request → each instruction takes 5 cycles; mem_addr is stable during the waits; final r1=2.
- MOVI r2,7; CMPI r2,7; BEQ +3 → PC jumps to branch_addr+3. Repeat with CMPI r2,8 → falls through to branch_addr+1. BLT after comparing r2 (0xFFFF) against 1 → taken, because signed −1 < 1.
- MOVI r3,0x40; MOVI r4,0x5A; STOR r4,r3; LOAD r5,r3 → a write cycle at address 0x40 with data 0x5A; r5=0x5A; LOAD retires 3 cycles after issue.
- Drop reset during a STOR in MEM with mem_ready=0 → mem_req=0 immediately; memory is not written; after release, pc=RESET_PC and all registers are 0.
- DATA_W=32, ADDR_W=8: MOVI r1,-1; ADDI r1,1 → r1=0. Branch with disp −5 at address 2 → PC=253.
